// File: rtl/ifm_window_buf_pkg.sv
// ---------------------------------------------------------------------------
// ifm_buf_pkg
// Shared types and default parameter values for the IFM window buffer.
// It holds the control-state enum and the default configuration constants.
// It declares no ports.
// ---------------------------------------------------------------------------
package ifm_buf_pkg;

   typedef enum logic {
      FILL   = 1'b0,
      STREAM = 1'b1
   } buf_state_t;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_TAPS   = 4;
   localparam int DEF_LANES  = 1;
   localparam int DEF_STRIDE = 1;

endpackage

// File: rtl/ifm_window_buf_if.sv
// ---------------------------------------------------------------------------
// ifm_window_buf_if
// Bus between the IFM fetch path (master) and the window buffer (slave).
//   ifm_input  : LANES*DATA_W new sample per lane
//   ifm_read   : shift enable
//   ifm_clear  : synchronous flush
//   ifm_window : LANES*TAPS*DATA_W window, lane l tap k at (l*TAPS+k)*DATA_W
//   win_valid  : complete, stride-aligned window present
//   fill_cnt   : samples accepted since clear/reset, saturating at TAPS
//   streaming  : buffer is in STREAM state
// ---------------------------------------------------------------------------
interface ifm_window_buf_if #(
   parameter int DATA_W = 8,
   parameter int TAPS   = 4,
   parameter int LANES  = 1
);
   localparam int CNT_W = $clog2(TAPS + 1);

   logic [LANES*DATA_W-1:0]      ifm_input;
   logic                         ifm_read;
   logic                         ifm_clear;
   logic [LANES*TAPS*DATA_W-1:0] ifm_window;
   logic                         win_valid;
   logic [CNT_W-1:0]             fill_cnt;
   logic                         streaming;

   modport master (
      output ifm_input, ifm_read, ifm_clear,
      input  ifm_window, win_valid, fill_cnt, streaming
   );

   modport slave (
      input  ifm_input, ifm_read, ifm_clear,
      output ifm_window, win_valid, fill_cnt, streaming
   );
endinterface

// File: rtl/ifm_window_buf_tap_chain.sv
// ---------------------------------------------------------------------------
// ifm_tap_chain
// One lane of the window buffer: a TAPS-deep signed shift register.
//   clk, rst_n : clock, async active-low reset (taps cleared)
//   shift      : accept din into tap 0, move older taps down by one
//   clear      : zero all taps; wins over shift
//   din        : new signed sample
//   window     : flattened taps, tap k at [k*DATA_W +: DATA_W], tap 0 newest
// ---------------------------------------------------------------------------
module ifm_tap_chain #(
   parameter int DATA_W = 8,
   parameter int TAPS   = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     shift,
   input  logic                     clear,
   input  logic signed [DATA_W-1:0] din,
   output logic [TAPS*DATA_W-1:0]   window
);

   logic signed [DATA_W-1:0] tap_p0 [TAPS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < TAPS; k++) tap_p0[k] <= '0;
      end else if (clear) begin
         for (int k = 0; k < TAPS; k++) tap_p0[k] <= '0;
      end else if (shift) begin
         tap_p0[0] <= din;
         for (int k = 1; k < TAPS; k++) tap_p0[k] <= tap_p0[k-1];
      end
   end

   for (genvar k = 0; k < TAPS; k++) begin : g_tap
      assign window[k*DATA_W +: DATA_W] = tap_p0[k];
   end

endmodule

// File: rtl/ifm_window_buf.sv
// ---------------------------------------------------------------------------
// ifm_window_buf
// Multi-lane IFM sliding-window buffer with fill tracking and stride-gated
// window-valid generation, placed between the IFM fetch path and PE array.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : ifm_window_buf_if slave (ifm_input/ifm_read/ifm_clear in,
//           ifm_window/win_valid/fill_cnt/streaming out)
// All lanes share one FILL/STREAM controller; lanes differ only in data.
// ---------------------------------------------------------------------------
module ifm_window_buf
   import ifm_buf_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int TAPS   = DEF_TAPS,
   parameter int LANES  = DEF_LANES,
   parameter int STRIDE = DEF_STRIDE
) (
   input  logic              clk,
   input  logic              rst_n,
   ifm_window_buf_if.slave   bus
);

   localparam int CNT_W = $clog2(TAPS + 1);
   localparam int STR_W = (STRIDE > 1) ? $clog2(STRIDE) : 1;

   buf_state_t       state_p0, state_nxt;
   logic [CNT_W-1:0] fill_p0, fill_nxt;
   logic [STR_W-1:0] stride_p0, stride_nxt;
   logic             vld_p0, vld_nxt;

   // ---- data path: one tap chain per lane
   for (genvar l = 0; l < LANES; l++) begin : g_lane
      ifm_tap_chain #(
         .DATA_W (DATA_W),
         .TAPS   (TAPS)
      ) u_chain (
         .clk    (clk),
         .rst_n  (rst_n),
         .shift  (bus.ifm_read),
         .clear  (bus.ifm_clear),
         .din    (bus.ifm_input[l*DATA_W +: DATA_W]),
         .window (bus.ifm_window[l*TAPS*DATA_W +: TAPS*DATA_W])
      );
   end

   // ---- control: state and counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_p0  <= FILL;
         fill_p0   <= '0;
         stride_p0 <= '0;
         vld_p0    <= 1'b0;
      end else begin
         state_p0  <= state_nxt;
         fill_p0   <= fill_nxt;
         stride_p0 <= stride_nxt;
         vld_p0    <= vld_nxt;
      end
   end

   // ---- control: next-state logic
   // The shift that completes the fill raises the first window and restarts
   // the stride phase; afterwards every STRIDE-th shift raises win_valid.
   // Idle cycles leave stride_p0 untouched so the phase survives read gaps.
   always_comb begin
      state_nxt  = state_p0;
      fill_nxt   = fill_p0;
      stride_nxt = stride_p0;
      vld_nxt    = 1'b0;
      if (bus.ifm_clear) begin
         state_nxt  = FILL;
         fill_nxt   = '0;
         stride_nxt = '0;
      end else if (bus.ifm_read) begin
         case (state_p0)
            FILL: begin
               fill_nxt = fill_p0 + 1'b1;
               if (fill_p0 == CNT_W'(TAPS - 1)) begin
                  state_nxt  = STREAM;
                  stride_nxt = '0;
                  vld_nxt    = 1'b1;
               end
            end
            STREAM: begin
               if (stride_p0 == STR_W'(STRIDE - 1)) begin
                  stride_nxt = '0;
                  vld_nxt    = 1'b1;
               end else begin
                  stride_nxt = stride_p0 + 1'b1;
               end
            end
            default: state_nxt = FILL;
         endcase
      end
   end

   // ---- control: outputs straight from registers
   always_comb begin
      bus.win_valid = vld_p0;
      bus.fill_cnt  = fill_p0;
      bus.streaming = (state_p0 == STREAM);
   end

endmodule

// File: tb/tb_ifm_window_buf.sv
// ---------------------------------------------------------------------------
// tb_ifm_window_buf
// Directed bench for ifm_window_buf. Two instances run the same sample
// stream: u_a (LANES=2, STRIDE=1; lane1 gets the negated sample) and
// u_b (LANES=1, STRIDE=2). Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_ifm_window_buf;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   ifm_window_buf_if #(.DATA_W(8), .TAPS(4), .LANES(2)) if_a ();
   ifm_window_buf_if #(.DATA_W(8), .TAPS(4), .LANES(1)) if_b ();

   ifm_window_buf #(.DATA_W(8), .TAPS(4), .LANES(2), .STRIDE(1)) u_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if_a)
   );

   ifm_window_buf #(.DATA_W(8), .TAPS(4), .LANES(1), .STRIDE(2)) u_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Window of one lane, tap0 in the low byte.
   function automatic logic [31:0] win4(input int t0, input int t1, input int t2, input int t3);
      return {8'(t3), 8'(t2), 8'(t1), 8'(t0)};
   endfunction

   // Drive one cycle of stimulus, then return #1 after the active edge.
   task automatic cyc(input bit rd, input bit clr, input int v);
      if_a.ifm_input = {8'(-v), 8'(v)};
      if_a.ifm_read  = rd;
      if_a.ifm_clear = clr;
      if_b.ifm_input = 8'(v);
      if_b.ifm_read  = rd;
      if_b.ifm_clear = clr;
      @(posedge clk);
      #1;
      if_a.ifm_read  = 1'b0;
      if_a.ifm_clear = 1'b0;
      if_b.ifm_read  = 1'b0;
      if_b.ifm_clear = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n = 1'b0;
      if_a.ifm_input = '0; if_a.ifm_read = 1'b0; if_a.ifm_clear = 1'b0;
      if_b.ifm_input = '0; if_b.ifm_read = 1'b0; if_b.ifm_clear = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Reset state
      chk("rst_win_a",  if_a.ifm_window, 64'd0);
      chk("rst_vld_a",  64'(if_a.win_valid), 64'd0);
      chk("rst_fill_a", 64'(if_a.fill_cnt), 64'd0);
      chk("rst_str_a",  64'(if_a.streaming), 64'd0);
      chk("rst_win_b",  64'(if_b.ifm_window), 64'd0);
      #4 rst_n = 1'b1;
      @(posedge clk); #1;

      // Fill with 1..3: no window yet
      for (int n = 1; n <= 3; n++) begin
         cyc(1'b1, 1'b0, n);
         chk($sformatf("fill_vld_a%0d", n), 64'(if_a.win_valid), 64'd0);
         chk($sformatf("fill_cnt_a%0d", n), 64'(if_a.fill_cnt), 64'(n));
      end
      chk("fill_str_a", 64'(if_a.streaming), 64'd0);

      // 4th shift completes the first window on both instances
      cyc(1'b1, 1'b0, 4);
      chk("w1_vld_a",  64'(if_a.win_valid), 64'd1);
      chk("w1_lane0",  64'(if_a.ifm_window[31:0]), 64'(win4(4, 3, 2, 1)));
      chk("w1_lane1",  64'(if_a.ifm_window[63:32]), 64'(win4(-4, -3, -2, -1)));
      chk("w1_fill_a", 64'(if_a.fill_cnt), 64'd4);
      chk("w1_str_a",  64'(if_a.streaming), 64'd1);
      chk("w1_vld_b",  64'(if_b.win_valid), 64'd1);

      // Continuous shifts 5..10: stride 1 every shift, stride 2 on even shifts
      for (int n = 5; n <= 10; n++) begin
         cyc(1'b1, 1'b0, n);
         chk($sformatf("s1_vld_%0d", n), 64'(if_a.win_valid), 64'd1);
         chk($sformatf("s2_vld_%0d", n), 64'(if_b.win_valid), 64'((n % 2) == 0));
         if (n == 6) chk("s2_win_6", 64'(if_b.ifm_window), 64'(win4(6, 5, 4, 3)));
      end
      chk("sat_fill_a", 64'(if_a.fill_cnt), 64'd4);

      // Clear with a simultaneous read of 9
      cyc(1'b1, 1'b1, 9);
      chk("clr_win_a",  if_a.ifm_window, 64'd0);
      chk("clr_fill_a", 64'(if_a.fill_cnt), 64'd0);
      chk("clr_str_a",  64'(if_a.streaming), 64'd0);
      chk("clr_vld_a",  64'(if_a.win_valid), 64'd0);
      chk("clr_str_b",  64'(if_b.streaming), 64'd0);

      // Read gaps: shifts 1,2, three idle cycles, shifts 3,4
      cyc(1'b1, 1'b0, 1);
      cyc(1'b1, 1'b0, 2);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b0, 77);
         chk($sformatf("gap_win_%0d", i), 64'(if_a.ifm_window[31:0]), 64'(win4(2, 1, 0, 0)));
         chk($sformatf("gap_vld_%0d", i), 64'(if_a.win_valid), 64'd0);
      end
      cyc(1'b1, 1'b0, 3);
      chk("gap_vld_s3", 64'(if_a.win_valid), 64'd0);
      chk("gap_fill_3", 64'(if_a.fill_cnt), 64'd3);
      cyc(1'b1, 1'b0, 4);
      chk("gap_vld_s4", 64'(if_a.win_valid), 64'd1);
      chk("gap_win_s4", 64'(if_a.ifm_window[31:0]), 64'(win4(4, 3, 2, 1)));
      chk("gap_vld_b4", 64'(if_b.win_valid), 64'd1);

      // Stride phase across an idle cycle on the STRIDE=2 instance
      cyc(1'b1, 1'b0, 5);
      chk("ph_vld_b5", 64'(if_b.win_valid), 64'd0);
      cyc(1'b0, 1'b0, 0);
      chk("ph_vld_idle", 64'(if_b.win_valid), 64'd0);
      cyc(1'b1, 1'b0, 6);
      chk("ph_vld_b6", 64'(if_b.win_valid), 64'd1);
      chk("ph_win_b6", 64'(if_b.ifm_window), 64'(win4(6, 5, 4, 3)));

      // Async reset pulse between edges, mid-stream
      #2 rst_n = 1'b0;
      #1;
      chk("arst_win_a",  if_a.ifm_window, 64'd0);
      chk("arst_vld_a",  64'(if_a.win_valid), 64'd0);
      chk("arst_fill_a", 64'(if_a.fill_cnt), 64'd0);
      chk("arst_str_a",  64'(if_a.streaming), 64'd0);
      chk("arst_win_b",  64'(if_b.ifm_window), 64'd0);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;

      // First post-reset window needs four fresh shifts
      for (int n = 1; n <= 3; n++) begin
         cyc(1'b1, 1'b0, n + 20);
         chk($sformatf("post_vld_%0d", n), 64'(if_a.win_valid), 64'd0);
      end
      cyc(1'b1, 1'b0, 24);
      chk("post_vld_4", 64'(if_a.win_valid), 64'd1);
      chk("post_win_4", 64'(if_a.ifm_window[31:0]), 64'(win4(24, 23, 22, 21)));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
